// File: rtl/count_scan_pkg.sv
// Shared types and constants for the event-counter sequencer and its display scan.
package count_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    OVF  = 2'd3
  } state_t;

  localparam logic [1:0] DIG_THOU = 2'd0;
  localparam logic [1:0] DIG_HUND = 2'd1;
  localparam logic [1:0] DIG_TENS = 2'd2;
  localparam logic [1:0] DIG_UNIT = 2'd3;

  localparam int SCAN_DIV_DEF  = 4000;
  localparam int DB_CYCLES_DEF = 20000;

  // Digit order thousands -> hundreds -> tens -> units -> thousands.
  function automatic logic [1:0] scan_next(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      DIG_THOU: nxt = DIG_HUND;
      DIG_HUND: nxt = DIG_TENS;
      DIG_TENS: nxt = DIG_UNIT;
      DIG_UNIT: nxt = DIG_THOU;
      default:  nxt = DIG_THOU;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/count_scan_ctrl_if.sv
// Input/strobe/display bundle between the sequencer (slave) and its surroundings (master).
interface count_scan_ctrl_if;

  logic       ev_in;
  logic       btn_ss;
  logic       btn_clr;
  logic       cnt_max;
  logic       cnt_inc;
  logic       cnt_clr;
  logic [1:0] scan;
  logic       scan_tick;
  logic       run;
  logic       ovf;

  modport master (
    output ev_in, btn_ss, btn_clr, cnt_max,
    input  cnt_inc, cnt_clr, scan, scan_tick, run, ovf
  );

  modport slave (
    input  ev_in, btn_ss, btn_clr, cnt_max,
    output cnt_inc, cnt_clr, scan, scan_tick, run, ovf
  );

endinterface

// File: rtl/count_scan_ctrl_sync_rise.sv
// Two-flop synchronizer, optional level debounce, and registered rising-edge pulse.
module sync_rise #(
  parameter int DB_CYCLES = 20000,
  parameter bit DEBOUNCE  = 1'b0
) (
  input  logic clk4m,
  input  logic clr_n,
  input  logic din,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;
  logic rise_r;
  logic lvl_s;

  // Metastability guard on the asynchronous input.
  always_ff @(posedge clk4m or negedge clr_n) begin
    if (!clr_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
    end
  end

  generate
    if (DEBOUNCE) begin : g_db
      localparam int DBW = $clog2(DB_CYCLES + 1);
      logic [DBW-1:0] db_cnt_r;
      logic           filt_r;

      // Filtered level follows s2 only after DB_CYCLES consecutive differing samples.
      always_ff @(posedge clk4m or negedge clr_n) begin
        if (!clr_n) begin
          db_cnt_r <= '0;
          filt_r   <= 1'b0;
        end else if (s2_r == filt_r) begin
          db_cnt_r <= '0;
        end else if (db_cnt_r == DBW'(DB_CYCLES - 1)) begin
          db_cnt_r <= '0;
          filt_r   <= s2_r;
        end else begin
          db_cnt_r <= db_cnt_r + {{(DBW-1){1'b0}}, 1'b1};
        end
      end

      assign lvl_s = filt_r;
    end else begin : g_nodb
      assign lvl_s = s2_r;
    end
  endgenerate

  // Edge detector; the pulse itself is registered so all inputs share one latency.
  always_ff @(posedge clk4m or negedge clr_n) begin
    if (!clr_n) begin
      s3_r   <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      s3_r   <= lvl_s;
      rise_r <= lvl_s & ~s3_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/count_scan_ctrl.sv
// Event-counter mode sequencer and digit-scan prescaler.
// Build option: COUNT_SCAN_DEBOUNCE_EN adds a debounce filter on btn_ss/btn_clr.
module count_scan_ctrl
  import count_scan_pkg::*;
#(
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter bit STOP_AT_MAX = 1'b0,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic               clk4m,
  input  logic               clr_n,
  count_scan_ctrl_if.slave   bus
);

`ifdef COUNT_SCAN_DEBOUNCE_EN
  localparam bit BTN_DB = 1'b1;
`else
  localparam bit BTN_DB = 1'b0;
`endif

  localparam int PW = $clog2(SCAN_DIV);

  logic          ev_rise_s;
  logic          ss_rise_s;
  logic          clr_rise_s;
  logic [PW-1:0] pre_r;
  logic [1:0]    scan_r;
  logic          tick_r;
  state_t        state_r;
  state_t        state_n;
  logic          inc_s;
  logic          clr_s;
  logic          inc_r;
  logic          clr_r;
  logic          run_r;
  logic          ovf_r;

  sync_rise #(.DB_CYCLES(DB_CYCLES), .DEBOUNCE(1'b0)) u_ev (
    .clk4m(clk4m), .clr_n(clr_n), .din(bus.ev_in), .rise(ev_rise_s)
  );

  sync_rise #(.DB_CYCLES(DB_CYCLES), .DEBOUNCE(BTN_DB)) u_ss (
    .clk4m(clk4m), .clr_n(clr_n), .din(bus.btn_ss), .rise(ss_rise_s)
  );

  sync_rise #(.DB_CYCLES(DB_CYCLES), .DEBOUNCE(BTN_DB)) u_clr (
    .clk4m(clk4m), .clr_n(clr_n), .din(bus.btn_clr), .rise(clr_rise_s)
  );

  // Free-running scan prescaler, independent of the counting mode.
  always_ff @(posedge clk4m or negedge clr_n) begin
    if (!clr_n) begin
      pre_r  <= '0;
      scan_r <= DIG_THOU;
      tick_r <= 1'b0;
    end else if (pre_r == PW'(SCAN_DIV - 1)) begin
      pre_r  <= '0;
      scan_r <= scan_next(scan_r);
      tick_r <= 1'b1;
    end else begin
      pre_r  <= pre_r + {{(PW-1){1'b0}}, 1'b1};
      tick_r <= 1'b0;
    end
  end

  // Mode next-state and strobe decode; clear wins over everything else.
  always_comb begin
    state_n = state_r;
    inc_s   = 1'b0;
    clr_s   = 1'b0;
    if (clr_rise_s) begin
      clr_s   = 1'b1;
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (ss_rise_s) state_n = RUN;
          else           state_n = IDLE;
        end
        RUN: begin
          if (ev_rise_s && bus.cnt_max && STOP_AT_MAX) begin
            state_n = OVF;
          end else begin
            inc_s = ev_rise_s;
            if (ss_rise_s) state_n = HOLD;
            else           state_n = RUN;
          end
        end
        HOLD: begin
          if (ss_rise_s) state_n = RUN;
          else           state_n = HOLD;
        end
        OVF:     state_n = OVF;
        default: state_n = IDLE;
      endcase
    end
  end

  // State and registered outputs; run/ovf decoded from next state to align with state_r.
  always_ff @(posedge clk4m or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= IDLE;
      inc_r   <= 1'b0;
      clr_r   <= 1'b0;
      run_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      inc_r   <= inc_s;
      clr_r   <= clr_s;
      run_r   <= (state_n == RUN);
      ovf_r   <= (state_n == OVF);
    end
  end

  assign bus.cnt_inc   = inc_r;
  assign bus.cnt_clr   = clr_r;
  assign bus.scan      = scan_r;
  assign bus.scan_tick = tick_r;
  assign bus.run       = run_r;
  assign bus.ovf       = ovf_r;

endmodule
